mmcu_folded: RTL and testbench

Time-multiplexed metric computation unit computing squared Euclidean distances |u − h·s|² between one received equalised symbol and every constellation point of the selected APSK mode. It uses LANES parallel metric lanes folded over ceil(N/LANES) cycles instead of one unit per symbol. It sits between the channel/equaliser front end and the LLR min-search stage, and streams metric groups under a valid/ready handshake.

---
 rtl/mmcu_folded.sv | 153 +++++++++++++++
 tb/tb_mmcu_folded.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmcu_folded.sv
// ============================================================================
//  Module   : mmcu_folded
//  Purpose  : Folded squared-distance metric unit, LANES lanes per cycle.
//             Build option MMCU_FOLD_SAT_EN saturates metrics instead of wrapping.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mmcu_folded #(
  parameter int WL      = 18,
  parameter int FRAC    = 10,
  parameter int LANES   = 8,
  parameter int SYM_MAX = 64,
  parameter int GW      = (SYM_MAX / LANES > 1) ? $clog2(SYM_MAX / LANES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WL-1:0]         u_re,
  input  logic [WL-1:0]         u_im,
  input  logic [WL-1:0]         h,
  input  logic [2:0]            mode,
  output logic [GW-1:0]         lut_grp,
  input  logic [LANES*WL-1:0]   lut_re,
  input  logic [LANES*WL-1:0]   lut_im,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*WL-1:0]   out_metric,
  output logic [GW-1:0]         out_grp,
  output logic [LANES-1:0]      out_mask,
  output logic                  out_last
);

  localparam int c_lane_lg = $clog2(LANES);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                 state_q;
  logic signed [WL-1:0]   u_re_q, u_im_q, h_q;
  logic [2:0]             mode_q;
  logic [GW-1:0]          grp_q;
  logic                   out_valid_q, out_last_q;
  logic [LANES*WL-1:0]    out_metric_q;
  logic [GW-1:0]          out_grp_q;
  logic [LANES-1:0]       out_mask_q;

  logic [2:0]             mode_eff_d;
  logic [7:0]             n_d, gcnt_d, base_d;
  logic                   last_d, issue_d;
  logic [LANES-1:0]       mask_d;
  logic [LANES*WL-1:0]    metric_d;

  // Reserved modes 5..7 fall back to the 4-point constellation.
  assign mode_eff_d = (mode_q > 3'd4) ? 3'd0 : mode_q;
  assign n_d        = 8'd4 << mode_eff_d;
  assign gcnt_d     = ((n_d >> c_lane_lg) == 8'd0) ? 8'd1 : (n_d >> c_lane_lg);
  assign base_d     = 8'(grp_q) << c_lane_lg;
  assign last_d     = (8'(grp_q) == (gcnt_d - 8'd1));
  assign issue_d    = (state_q == S_RUN) && (!out_valid_q || out_ready);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [WL-1:0]   s_re, s_im;
    logic signed [2*WL-1:0] prod_re, prod_im, prod_re_sh, prod_im_sh;
    logic signed [WL:0]     d_re, d_im;
    logic signed [2*WL+1:0] sq_re, sq_im;
    logic [2*WL+2:0]        sum;
    logic [2*WL+2-FRAC:0]   m_full;
    logic [WL-1:0]          m_lim;
    logic                   lane_unused;

    assign s_re       = lut_re[k*WL +: WL];
    assign s_im       = lut_im[k*WL +: WL];
    assign prod_re    = h_q * s_re;
    assign prod_im    = h_q * s_im;
    assign prod_re_sh = prod_re >>> FRAC;
    assign prod_im_sh = prod_im >>> FRAC;
    assign d_re       = {u_re_q[WL-1], u_re_q} - prod_re_sh[WL:0];
    assign d_im       = {u_im_q[WL-1], u_im_q} - prod_im_sh[WL:0];
    assign sq_re      = d_re * d_re;
    assign sq_im      = d_im * d_im;
    assign sum        = {1'b0, sq_re} + {1'b0, sq_im};
    assign m_full     = sum[2*WL+2:FRAC];
`ifdef MMCU_FOLD_SAT_EN
    assign m_lim      = (|m_full[2*WL+2-FRAC:WL]) ? {WL{1'b1}} : m_full[WL-1:0];
`else
    assign m_lim      = m_full[WL-1:0];
`endif
    assign lane_unused = ^{prod_re_sh[2*WL-1:WL+1], prod_im_sh[2*WL-1:WL+1],
                           sum[FRAC-1:0], m_full};

    // Lanes past the constellation end read as maximal distance.
    assign mask_d[k]             = (base_d + 8'(k)) < n_d;
    assign metric_d[k*WL +: WL]  = mask_d[k] ? m_lim : {WL{1'b1}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      u_re_q       <= '0;
      u_im_q       <= '0;
      h_q          <= '0;
      mode_q       <= '0;
      grp_q        <= '0;
      out_valid_q  <= 1'b0;
      out_metric_q <= '0;
      out_grp_q    <= '0;
      out_mask_q   <= '0;
      out_last_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            u_re_q  <= u_re;
            u_im_q  <= u_im;
            h_q     <= h;
            mode_q  <= mode;
            grp_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (issue_d) begin
            grp_q <= last_d ? '0 : grp_q + 1'b1;
            if (last_d) state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (issue_d) begin
        out_valid_q  <= 1'b1;
        out_metric_q <= metric_d;
        out_grp_q    <= grp_q;
        out_mask_q   <= mask_d;
        out_last_q   <= last_d;
      end else if (out_ready) begin
        out_valid_q  <= 1'b0;
      end
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign lut_grp    = grp_q;
  assign out_valid  = out_valid_q;
  assign out_metric = out_metric_q;
  assign out_grp    = out_grp_q;
  assign out_mask   = out_mask_q;
  assign out_last   = out_last_q;

endmodule

`default_nettype wire

// File: tb/tb_mmcu_folded.sv
// ============================================================================
//  Module   : tb_mmcu_folded
//  Purpose  : Self-checking bench for mmcu_folded against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mmcu_folded;
  localparam int WL = 18, FRAC = 10, LANES = 8, SYM_MAX = 64, GW = 3;
  localparam longint MAXV = (longint'(1) << WL) - 1;
`ifdef MMCU_FOLD_SAT_EN
  localparam longint SAT_EXP = 262143;
`else
  localparam longint SAT_EXP = 261632;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, out_valid, out_ready, out_last;
  logic [WL-1:0] u_re, u_im, h;
  logic [2:0] mode;
  logic [GW-1:0] lut_grp, out_grp;
  logic [LANES*WL-1:0] lut_re, lut_im, out_metric;
  logic [LANES-1:0] out_mask;

  logic signed [WL-1:0] mem_re [SYM_MAX];
  logic signed [WL-1:0] mem_im [SYM_MAX];
  bit rdy_rand;
  int n_checks = 0, n_err = 0;

  typedef struct {
    logic [LANES*WL-1:0] metric;
    int                  grp;
    logic [LANES-1:0]    mask;
    bit                  last;
  } grp_t;
  grp_t exp_q[$];
  grp_t e_cur;

  always #5 clk = ~clk;

  mmcu_folded #(.WL(WL), .FRAC(FRAC), .LANES(LANES), .SYM_MAX(SYM_MAX), .GW(GW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .u_re(u_re), .u_im(u_im), .h(h), .mode(mode), .lut_grp(lut_grp),
    .lut_re(lut_re), .lut_im(lut_im), .out_valid(out_valid), .out_ready(out_ready),
    .out_metric(out_metric), .out_grp(out_grp), .out_mask(out_mask), .out_last(out_last)
  );

  always_comb begin
    lut_re = '0;
    lut_im = '0;
    for (int k = 0; k < LANES; k++) begin
      lut_re[k*WL +: WL] = mem_re[int'(lut_grp) * LANES + k];
      lut_im[k*WL +: WL] = mem_im[int'(lut_grp) * LANES + k];
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [LANES*WL-1:0] act,
                         input logic [LANES*WL-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic longint wrap_s(input longint v, input int bits);
    longint m, r;
    m = longint'(1) << bits;
    r = v % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  // Squared distance |u - h*s|^2 scaled by 2^-FRAC, limited to WL bits.
  function automatic longint lane_metric(input longint ur, ui, hh, sr, si);
    longint pr, pi, dr, di, m;
    pr = wrap_s((hh * sr) >>> FRAC, WL + 1);
    pi = wrap_s((hh * si) >>> FRAC, WL + 1);
    dr = wrap_s(ur - pr, WL + 1);
    di = wrap_s(ui - pi, WL + 1);
    m  = (dr * dr + di * di) >>> FRAC;
`ifdef MMCU_FOLD_SAT_EN
    if (m > MAXV) m = MAXV;
`else
    m = m % (MAXV + 1);
`endif
    return m;
  endfunction

  task automatic predict();
    int md, npts, ng, idx;
    longint m;
    grp_t e;
    md   = (int'(mode) > 4) ? 0 : int'(mode);
    npts = 4 << md;
    ng   = npts / LANES;
    if (ng < 1) ng = 1;
    for (int g = 0; g < ng; g++) begin
      e.grp = g; e.last = (g == ng - 1); e.metric = '0; e.mask = '0;
      for (int k = 0; k < LANES; k++) begin
        idx = g * LANES + k;
        if (idx < npts) begin
          e.mask[k] = 1'b1;
          m = lane_metric(longint'($signed(u_re)), longint'($signed(u_im)),
                          longint'($signed(h)), longint'(mem_re[idx]), longint'(mem_im[idx]));
        end else begin
          m = MAXV;
        end
        e.metric[k*WL +: WL] = WL'(m);
      end
      exp_q.push_back(e);
    end
  endtask

  // Compare process: the presented group must always equal the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) predict();
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("stray_valid", out_valid, 0);
        end else begin
          e_cur = exp_q[0];
          chk_vec("metric", out_metric, e_cur.metric);
          chk("grp_mask_last", longint'({out_grp, out_mask, out_last}),
              longint'({GW'(e_cur.grp), e_cur.mask, e_cur.last}));
          if (out_ready) void'(exp_q.pop_front());
        end
        if (!out_ready && !out_last) begin
          chk("lut_grp_stall", lut_grp, int'(out_grp) + 1);
          chk("in_ready_stall", in_ready, 0);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WL-1:0] rnd_s();
    if ($urandom_range(0, 3) == 0) return WL'($urandom);
    return WL'($urandom_range(0, 8191)) - WL'(4096);
  endfunction

  task automatic rnd_mem();
    for (int i = 0; i < SYM_MAX; i++) begin
      mem_re[i] = rnd_s();
      mem_im[i] = rnd_s();
    end
  endtask

  task automatic send(input logic [WL-1:0] ur, ui, hh, input logic [2:0] md);
    int n;
    n = 0;
    u_re = ur; u_im = ui; h = hh; mode = md; in_valid = 1'b1;
    while (!in_ready && n < 500) begin
      step();
      n++;
    end
    chk("send_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && in_ready && !out_valid) && n < 1000) begin
      step();
      n++;
    end
    chk("drain_done", longint'(exp_q.size() == 0 && in_ready && !out_valid), 1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk_vec({tag, "_out_metric"}, out_metric, '0);
    chk({tag, "_out_grp"}, out_grp, 0);
    chk({tag, "_out_mask"}, out_mask, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_lut_grp"}, lut_grp, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LANES*WL-1:0] v_exp;
    rst_n = 1'b1; in_valid = 1'b0; u_re = '0; u_im = '0; h = '0; mode = '0;
    out_ready = 1'b1; rdy_rand = 1'b0;
    for (int i = 0; i < SYM_MAX; i++) begin
      mem_re[i] = '0;
      mem_im[i] = '0;
    end
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("por");
    rst_n = 1'b1;
    step();
    chk("por_in_ready_rel", in_ready, 1);

    // 64-point symbol: only point 0 coincides with u.
    mem_re[0] = 18'sd1024;
    send(18'd1024, 18'd0, 18'd1024, 3'd4);
    for (int g = 0; g < 8; g++) begin
      step();
      chk("m4_valid", out_valid, 1);
      chk("m4_grp", out_grp, g);
      chk("m4_last", out_last, longint'(g == 7));
      for (int k = 0; k < LANES; k++) v_exp[k*WL +: WL] = WL'(1024);
      if (g == 0) v_exp[WL-1:0] = '0;
      chk_vec("m4_metric", out_metric, v_exp);
    end
    drain();

    // 4-point symbol: single group with upper half masked.
    rnd_mem();
    send(rnd_s(), rnd_s(), rnd_s(), 3'd0);
    step();
    chk("m0_valid", out_valid, 1);
    chk("m0_mask", out_mask, 8'h0F);
    chk("m0_last", out_last, 1);
    v_exp = '0;
    v_exp[4*WL-1:0] = '1;
    chk_vec("m0_upper", out_metric >> (4*WL), v_exp);
    drain();

    // Overflowing distance on lane 0.
    mem_re[0] = 18'sh20000;
    mem_im[0] = '0;
    send(18'd131071, 18'd0, 18'd1024, 3'd0);
    step();
    chk("sat_lane0", out_metric[WL-1:0], SAT_EXP);
    drain();

    // Backpressure over 32-point symbols, sent without draining.
    rdy_rand = 1'b1;
    rnd_mem();
    for (int s = 0; s < 6; s++) send(rnd_s(), rnd_s(), rnd_s(), 3'd3);
    drain();

    // Random modes including reserved ones.
    for (int b = 0; b < 3; b++) begin
      rnd_mem();
      for (int s = 0; s < 5; s++) send(rnd_s(), rnd_s(), rnd_s(), 3'($urandom_range(0, 7)));
      drain();
    end

    // Back-to-back 8-point symbols with in_valid held high.
    rdy_rand = 1'b0;
    step();
    rnd_mem();
    u_re = rnd_s(); u_im = rnd_s(); h = rnd_s(); mode = 3'd1;
    in_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      step();
      chk("b2b_valid", out_valid, c % 2);
      chk("b2b_in_ready", in_ready, c % 2);
      if (!in_ready) begin
        u_re = rnd_s(); u_im = rnd_s(); h = rnd_s();
      end
    end
    in_valid = 1'b0;
    drain();

    // Reset in the middle of a 64-point symbol.
    send(rnd_s(), rnd_s(), rnd_s(), 3'd4);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk_reset_outs("mid");
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("post_rst_valid", out_valid, 0);
      chk("post_rst_in_ready", in_ready, 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
